text_scan_ctrl: RTL

Parametrised character-grid scan controller for the text-mode display path. Driven by the VGA timing strobes, it generates video-memory read addresses for a COLS x ROWS character grid. It also provides hardware vertical scrolling with wrap-around, the current glyph scanline, and a blinking underline cursor flag aligned to the RAM read data. It sits between the `vga` timing block and the 1-cycle-latency video RAM, and feeds `ascii_to_pixel`.

---
 rtl/text_scan_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/text_scan_ctrl.sv
// Character-grid scan controller: turns VGA line/pixel strobes into video RAM
// read addresses with vertical scroll wrap, glyph scanline and blinking cursor.
module text_scan_ctrl #(
   parameter int unsigned COLS         = 50,
   parameter int unsigned ROWS         = 24,
   parameter int unsigned GLYPH_H      = 20,
   parameter int unsigned CURSOR_H     = 2,
   parameter int unsigned BLINK_FRAMES = 30,
   parameter int unsigned ADDR_W       = 11,
   localparam int unsigned COL_W       = $clog2(COLS),
   localparam int unsigned ROW_W       = $clog2(ROWS),
   localparam int unsigned LINE_W      = $clog2(GLYPH_H)
) (
   input  logic              CLK_VGA,
   input  logic              reset,
   input  logic              newData,
   input  logic              end_of_line,
   input  logic              end_of_frame,
   input  logic [ROW_W-1:0]  scroll_row,
   input  logic              cursor_en,
   input  logic [ADDR_W-1:0] cursor_addr,
   output logic [ADDR_W-1:0] read_addr,
   output logic [LINE_W-1:0] line_number,
   output logic              cursor_hit,
   output logic              frame_done
);

   localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(ROWS - 1);
   localparam logic [LINE_W-1:0]  LINE_LAST  = LINE_W'(GLYPH_H - 1);
   localparam logic [LINE_W-1:0]  CUR_FIRST  = LINE_W'(GLYPH_H - CURSOR_H);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
   localparam logic [ADDR_W:0]    CELLS      = (ADDR_W+1)'(ROWS * COLS);
   localparam logic [ADDR_W:0]    COLS_X     = (ADDR_W+1)'(COLS);

   // The whole grid must be addressable by the video RAM.
   if (ROWS * COLS > (1 << ADDR_W)) begin : g_addr_check
      $error("text_scan_ctrl: ROWS*COLS exceeds 2**ADDR_W");
   end

   typedef enum logic {
      ST_SCAN = 1'b0,
      ST_DONE = 1'b1
   } state_e;

   state_e               state_q, state_d;
   logic [COL_W-1:0]     col_q, col_d;
   logic [LINE_W-1:0]    line_q, line_d;
   logic [ROW_W-1:0]     row_q, row_d;
   logic [ADDR_W-1:0]    row_base_q, row_base_d;
   logic [ROW_W-1:0]     shadow_q, shadow_d;
   logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
   logic                 blink_on_q, blink_on_d;
   logic [ADDR_W-1:0]    read_addr_q, read_addr_d;
   logic [LINE_W-1:0]    line_number_q, line_number_d;
   logic                 cursor_hit_q, cursor_hit_d;
   logic [ADDR_W:0]      row_base_inc;

   always_ff @(posedge CLK_VGA or posedge reset) begin
      if (reset) begin
         state_q       <= ST_SCAN;
         col_q         <= '0;
         line_q        <= '0;
         row_q         <= '0;
         row_base_q    <= '0;
         shadow_q      <= '0;
         blink_cnt_q   <= '0;
         blink_on_q    <= 1'b1;
         read_addr_q   <= '0;
         line_number_q <= '0;
         cursor_hit_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         col_q         <= col_d;
         line_q        <= line_d;
         row_q         <= row_d;
         row_base_q    <= row_base_d;
         shadow_q      <= shadow_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_on_q    <= blink_on_d;
         read_addr_q   <= read_addr_d;
         line_number_q <= line_number_d;
         cursor_hit_q  <= cursor_hit_d;
      end
   end

   // Strobe handling: end_of_frame > end_of_line > newData.
   always_comb begin
      state_d      = state_q;
      col_d        = col_q;
      line_d       = line_q;
      row_d        = row_q;
      row_base_d   = row_base_q;
      shadow_d     = shadow_q;
      blink_cnt_d  = blink_cnt_q;
      blink_on_d   = blink_on_q;
      row_base_inc = {1'b0, row_base_q} + COLS_X;

      if (end_of_frame) begin
         state_d    = ST_SCAN;
         col_d      = '0;
         line_d     = '0;
         row_d      = '0;
         shadow_d   = (scroll_row > ROW_LAST) ? '0 : scroll_row;
         row_base_d = ADDR_W'(32'(shadow_d) * COLS);
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_on_d  = ~blink_on_q;
         end else begin
            blink_cnt_d = blink_cnt_q + BLINK_W'(1);
         end
      end else if (state_q == ST_SCAN) begin
         if (end_of_line) begin
            if (line_q != LINE_LAST) begin
               col_d  = '0;
               line_d = line_q + LINE_W'(1);
            end else if (row_q == ROW_LAST) begin
               // Last scanline of the frame: freeze until end_of_frame.
               state_d = ST_DONE;
            end else begin
               col_d      = '0;
               line_d     = '0;
               row_d      = row_q + ROW_W'(1);
               row_base_d = (row_base_inc >= CELLS) ? '0 : row_base_inc[ADDR_W-1:0];
            end
         end else if (newData && (col_q != COL_LAST)) begin
            col_d = col_q + COL_W'(1);
         end
      end

      read_addr_d   = row_base_d + ADDR_W'(col_d);
      line_number_d = line_q;
      cursor_hit_d  = cursor_en & blink_on_q & (read_addr_q == cursor_addr) &
                      (line_q >= CUR_FIRST);
   end

   assign read_addr   = read_addr_q;
   assign line_number = line_number_q;
   assign cursor_hit  = cursor_hit_q;
   assign frame_done  = (state_q == ST_DONE);

endmodule
